// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the pushbutton debouncer: per-key FSM state
// encoding and the width helper used to size the stability counter.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned bits;
    longint unsigned span;
    bits = 0;
    span = 1;
    while (span < longint'(n)) begin
      span = span << 1;
      bits = bits + 1;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key bus between the board pushbuttons, the debouncer and the data generator.
// The master drives the raw keys; the debouncer (slave) returns the conditioned view.
interface key_debouncer_if #(
  parameter int NUM_KEYS = 2
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debouncer_chan.sv
// One debounced key: two-flop synchronizer, four-state debounce FSM and a
// stability counter. All outputs are registered.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic sysRst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RAW_IDLE = KEY_ACTIVE_LOW;

  logic sync_p0;
  logic sync_p1;
  logic pressed_s;

  key_state_e       state;
  key_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Stage p0/p1: bring the asynchronous raw level into the clk domain.
  always_ff @(posedge clk or negedge sysRst) begin
    if (!sysRst) begin
      sync_p0 <= RAW_IDLE;
      sync_p1 <= RAW_IDLE;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_s = KEY_ACTIVE_LOW ? ~sync_p1 : sync_p1;

  // Debounce stage: state, counter and registered outputs.
  always_ff @(posedge clk or negedge sysRst) begin
    if (!sysRst) begin
      state       <= RELEASED;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      RELEASED: begin
        if (pressed_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/key_debouncer.sv
// Pushbutton conditioning front end: one independent debounce channel per key,
// collected onto the key bus seen by the downstream data generator.
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            sysRst,
  key_debouncer_if.slave  kbus
);

  logic [NUM_KEYS-1:0] level_v;
  logic [NUM_KEYS-1:0] press_v;
  logic [NUM_KEYS-1:0] release_v;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .sysRst      (sysRst),
      .key_raw     (kbus.key_raw[g]),
      .key_level   (level_v[g]),
      .key_press   (press_v[g]),
      .key_release (release_v[g])
    );
  end

  assign kbus.key_level   = level_v;
  assign kbus.key_press   = press_v;
  assign kbus.key_release = release_v;

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Upstream conditioning stage for the board pushbuttons. It synchronizes and debounces the raw key inputs.
- It produces clean active-high key levels plus one-cycle press/release pulses.
- key_level drives the key bus of the 4-bit data generator, so that block's counter sees exactly one rising edge per physical press.

Parameters:
- NUM_KEYS, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clk cycles required to accept a level change. Default is 20 ms at 50 MHz. Legal range is 1 or more.
- KEY_ACTIVE_LOW, 1: 1 means key_raw is low when pressed; 0 means high when pressed.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- sysRst, in, 1: reset sysRst, asynchronous, active-low.
- key_raw, in, NUM_KEYS: raw asynchronous pushbutton inputs.
- key_level, out, NUM_KEYS: debounced level, 1 = pressed.
- key_press, out, NUM_KEYS: one-cycle pulse on accepted press.
- key_release, out, NUM_KEYS: one-cycle pulse on accepted release.

Behaviour:
- Channels are fully independent. Simultaneous events on different keys are handled in parallel, with no priority.
- Synchronizer: two flops per key. Reset value is the inactive raw level (1 if KEY_ACTIVE_LOW). Output is polarity-normalized to s = 1 when pressed.
- Reset: state RELEASED, counter 0, key_level/key_press/key_release all 0. Assertion takes effect immediately, mid-operation included.
- Counter width is clog2(DEBOUNCE_CYCLES+1). It never wraps; it is cleared on every state entry.
- FSM per key (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT):
  - RELEASED: s=1 goes to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: s=0 returns to RELEASED with no output (bounce). If s=1 and cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set key_level=1 and pulse key_press. Otherwise cnt++.
  - PRESSED: s=0 goes to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: s=1 returns to PRESSED with no output. If s=0 and cnt==DEBOUNCE_CYCLES-1, go to RELEASED, set key_level=0 and pulse key_release. Otherwise cnt++.
- All outputs are registered.
- Latency: if raw is first sampled active at edge 1 and held stable, key_level rises and key_press is high for the cycle following edge DEBOUNCE_CYCLES+3. Release timing is symmetric.
- key_press and key_release are high for exactly one cycle. They are never both high on the same key. Two successive pulses on one key are at least DEBOUNCE_CYCLES+1 cycles apart.
- Any instability shorter than DEBOUNCE_CYCLES cycles produces no output change.
- Key held through reset deassertion: treated as a new press. A full debounce runs, then key_press pulses.
- Reset during PRESS_WAIT or RELEASE_WAIT: the partial count is discarded and no pulse is emitted.

Decomposition:
- Shared package key_pkg holds:
  - 2-bit state encoding constants RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - A clog2 width function for the counter.
- Sub-module key_debounce_chan: synchronizer, FSM and counter for one key. key_debouncer instantiates it NUM_KEYS times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1):
1. sysRst low with key_raw=2'b11 → key_level=0, key_press=0, key_release=0. Release reset with key_raw[1]=0 held from edge 1 → key_press[1] pulses after edge 7.
2. Clean press: key_raw[1] goes low at edge 1 and is held → key_level[1]=1 and key_press[1]=1 for one cycle after edge 7. key_level[0] stays 0 and never pulses.
3. Bounce: key_raw[1] low 2 cycles, high 1, low 3, high 1, then low held → no pulse until 4 stable cycles complete, then exactly one key_press[1] pulse.
4. Release: from pressed, key_raw[1] high for 3 cycles then low → no change. Then high held → key_level[1]=0 and key_release[1] pulses after edge 7.
5. Both keys go low on the same edge → key_press=2'b11 on the same single cycle, and key_level=2'b11 afterward.
6. sysRst pulsed low 2 cycles into PRESS_WAIT, key held low → no pulse during or at reset. key_press pulses after edge 7 counted from reset release.
